// File: rtl/m_w_load_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_w_load_stage_pkg
// Description : Shared load-op / write-data-source codes, the PC reset value
//               and the load misalignment helper for the M/W load stage.
// Revision    : 1.0 - initial release
// ============================================================================
package m_w_load_stage_pkg;

  typedef logic [2:0] loadop_t;
  typedef logic [1:0] wdsel_t;

  // Load type codes
  localparam loadop_t LD_LW  = 3'd0;
  localparam loadop_t LD_LB  = 3'd1;
  localparam loadop_t LD_LBU = 3'd2;
  localparam loadop_t LD_LH  = 3'd3;
  localparam loadop_t LD_LHU = 3'd4;

  // Register write-data source codes (2'd3 selects zero)
  localparam wdsel_t WD_ALU = 2'd0;
  localparam wdsel_t WD_MEM = 2'd1;
  localparam wdsel_t WD_PC8 = 2'd2;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  // Only memory-sourced writes can be misaligned; byte loads and undefined
  // codes never are.
  function automatic logic load_misaligned(input logic [1:0] addr,
                                           input loadop_t    loadop,
                                           input wdsel_t     wdsel);
    logic mis;
    mis = 1'b0;
    if (wdsel == WD_MEM) begin
      case (loadop)
        LD_LH, LD_LHU: mis = addr[0];
        LD_LW:         mis = (addr != 2'b00);
        default:       mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

endpackage : m_w_load_stage_pkg
`default_nettype wire

// File: rtl/m_w_load_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : m_w_load_stage_if
// Description : M-stage inputs and W-stage outputs of the M/W load stage.
//               master = upstream pipeline / environment, slave = the stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface m_w_load_stage_if;

  logic        en;
  logic        flush;
  logic [31:0] M_pc;
  logic [31:0] M_instr;
  logic [31:0] M_aluout;
  logic [31:0] M_dmrd;
  logic [2:0]  M_loadop;
  logic        M_rfwe;
  logic [4:0]  M_rfwa;
  logic [1:0]  M_wdsel;

  logic [31:0] W_pc;
  logic [31:0] W_instr;
  logic        W_rfwe;
  logic [4:0]  W_rfwa;
  logic [31:0] W_rfwd;
  logic        W_misalign;

  modport master (
    output en, flush, M_pc, M_instr, M_aluout, M_dmrd,
           M_loadop, M_rfwe, M_rfwa, M_wdsel,
    input  W_pc, W_instr, W_rfwe, W_rfwa, W_rfwd, W_misalign
  );

  modport slave (
    input  en, flush, M_pc, M_instr, M_aluout, M_dmrd,
           M_loadop, M_rfwe, M_rfwa, M_wdsel,
    output W_pc, W_instr, W_rfwe, W_rfwa, W_rfwd, W_misalign
  );

endinterface : m_w_load_stage_if
`default_nettype wire

// File: rtl/m_w_load_stage_w_dext.sv
`default_nettype none
// ============================================================================
// Module      : m_w_load_stage_w_dext
// Description : W-stage load data extension. Selects a little-endian byte or
//               halfword from the memory word and sign/zero extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module m_w_load_stage_w_dext
  import m_w_load_stage_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  loadop_t     loadop_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection: byte lane k = word[8k+7:8k], halfword by addr[1]
  always_comb begin
    byte_sel = 8'h00;
    case (addr_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Extension by load type; LW and undefined codes pass the whole word
  always_comb begin
    data_o = word_i;
    case (loadop_i)
      LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data_o = {24'h000000, byte_sel};
      LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data_o = {16'h0000, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule : m_w_load_stage_w_dext
`default_nettype wire

// File: rtl/m_w_load_stage.sv
`default_nettype none
// ============================================================================
// Module      : m_w_load_stage
// Description : M/W pipeline register fused with W-stage load extension.
//               All W outputs derive from registered fields only.
// Revision    : 1.0 - initial release
// ============================================================================
module m_w_load_stage
  import m_w_load_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  m_w_load_stage_if.slave  bus
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] aluout_q;
  logic [31:0] dmrd_q;
  loadop_t     loadop_q;
  logic        rfwe_q;
  logic [4:0]  rfwa_q;
  wdsel_t      wdsel_q;
  logic        misalign_q;

  logic        misalign_d;
  logic [31:0] ext_data;
  logic [31:0] rfwd;

  // Misalignment is decided from the M-stage fields at latch time
  always_comb begin
    misalign_d = load_misaligned(bus.M_aluout[1:0], bus.M_loadop, bus.M_wdsel);
  end

  // Pipeline register: reset > flush > enable > hold
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      pc_q       <= PC_RESET;
      instr_q    <= 32'h0;
      aluout_q   <= 32'h0;
      dmrd_q     <= 32'h0;
      loadop_q   <= LD_LW;
      rfwe_q     <= 1'b0;
      rfwa_q     <= 5'd0;
      wdsel_q    <= WD_ALU;
      misalign_q <= 1'b0;
    end else if (bus.en) begin
      pc_q       <= bus.M_pc;
      instr_q    <= bus.M_instr;
      aluout_q   <= bus.M_aluout;
      dmrd_q     <= bus.M_dmrd;
      loadop_q   <= bus.M_loadop;
      rfwe_q     <= bus.M_rfwe;
      rfwa_q     <= bus.M_rfwa;
      wdsel_q    <= bus.M_wdsel;
      misalign_q <= misalign_d;
    end
  end

  m_w_load_stage_w_dext u_w_dext (
    .addr_i   (aluout_q[1:0]),
    .loadop_i (loadop_q),
    .word_i   (dmrd_q),
    .data_o   (ext_data)
  );

  // Write-data source select; misaligned loads still show extended data
  always_comb begin
    rfwd = 32'h0;
    case (wdsel_q)
      WD_ALU:  rfwd = aluout_q;
      WD_MEM:  rfwd = ext_data;
      WD_PC8:  rfwd = pc_q + 32'd8;
      default: rfwd = 32'h0;
    endcase
  end

  // Write enable suppressed for misaligned loads and for $0
  always_comb begin
    bus.W_pc       = pc_q;
    bus.W_instr    = instr_q;
    bus.W_rfwa     = rfwa_q;
    bus.W_rfwd     = rfwd;
    bus.W_misalign = misalign_q;
    bus.W_rfwe     = rfwe_q && !misalign_q && (rfwa_q != 5'd0);
  end

endmodule : m_w_load_stage
`default_nettype wire
